qtcore_scan_ctrl: RTL and testbench

- Parametrised pin-side controller between the TinyTapeout SPI-style pins and NUM_CORES qtcore instances.
- Scan frames are framed by an active-low chip select. Each frame begins with a core-select header, followed by exactly SCAN_LEN counted scan bits.
- A separate active-low run select enables execution of the selected core and returns its halt status on miso.
- Adds multi-core selection, frame length enforcement, abort detection and error reporting.

---
 rtl/qtcore_scan_ctrl_if.sv | 33 +++
 rtl/qtcore_scan_ctrl.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_qtcore_scan_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/qtcore_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// qtcore_scan_ctrl_if
//
// Pin-side bundle between the TinyTapeout SPI-style pins and the scan
// controller. The host (pin driver) is the master, the controller is the
// slave.
//
// Signals:
//   scan_cs_n  host -> ctrl  scan frame select, active low
//   proc_cs_n  host -> ctrl  run select, active low
//   sdi        host -> ctrl  serial data in
//   miso       ctrl -> host  serial data out / halt status
// ---------------------------------------------------------------------------
interface qtcore_scan_ctrl_if;
    logic scan_cs_n;
    logic proc_cs_n;
    logic sdi;
    logic miso;

    modport master (
        output scan_cs_n,
        output proc_cs_n,
        output sdi,
        input  miso
    );

    modport slave (
        input  scan_cs_n,
        input  proc_cs_n,
        input  sdi,
        output miso
    );
endinterface

// File: rtl/qtcore_scan_ctrl.sv
// ---------------------------------------------------------------------------
// qtcore_scan_ctrl
//
// Pin-side controller in front of NUM_CORES qtcore instances. A scan frame
// (scan_cs_n low) starts with a SEL_W-bit core-select header, MSB first,
// followed by exactly SCAN_LEN scan bits routed to the selected core. A run
// request (proc_cs_n low) enables execution of the selected core and
// reflects its halt flag on miso. Short frames, over-long frames, invalid
// core indices and simultaneous selects raise a sticky err flag.
//
// Optional feature (compile-time macro QTCORE_WDT_EN):
//   A run watchdog. While running, cycles with the selected core not halted
//   are counted; after WDT_CYCLES such cycles the core is stopped, err is
//   raised and miso reports "halted" until proc_cs_n is released.
//
// Ports:
//   clk            in   system clock, also the serial bit clock
//   rst            in   asynchronous reset, active low
//   pins           slave modport of qtcore_scan_ctrl_if
//                  (scan_cs_n, proc_cs_n, sdi in; miso out)
//   core_scan_en   out  one-hot scan enable, one bit per core
//   core_scan_in   out  scan data broadcast to all cores
//   core_scan_out  in   per-core scan data out
//   core_proc_en   out  one-hot processor enable
//   core_halt      in   per-core halt flag
//   sel            out  currently selected core index
//   frame_done     out  last frame completed with its full length
//   err            out  sticky error flag, cleared only by reset
// ---------------------------------------------------------------------------
module qtcore_scan_ctrl #(
    parameter int NUM_CORES  = 2,
    parameter int SEL_W      = 3,
    parameter int SCAN_LEN   = 192,
    parameter int WDT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    qtcore_scan_ctrl_if.slave    pins,
    output logic [NUM_CORES-1:0] core_scan_en,
    output logic                 core_scan_in,
    input  logic [NUM_CORES-1:0] core_scan_out,
    output logic [NUM_CORES-1:0] core_proc_en,
    input  logic [NUM_CORES-1:0] core_halt,
    output logic [SEL_W-1:0]     sel,
    output logic                 frame_done,
    output logic                 err
);

    // The bit counter is shared between header and scan phases, so it must
    // also be able to hold SEL_W-1.
    localparam int CNT_W = $clog2(SCAN_LEN + 1);

    if (NUM_CORES < 1 || NUM_CORES > 8 || SEL_W < 1 ||
        SCAN_LEN < SEL_W || WDT_CYCLES < 1) begin : g_bad_cfg
        $error("qtcore_scan_ctrl: unsupported parameter set");
    end

`ifdef QTCORE_WDT_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_SCAN,
        S_DONE,
        S_RUN,
        S_WDT
    } state_t;

    localparam int WDT_W = $clog2(WDT_CYCLES + 1);
`else
    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_SCAN,
        S_DONE,
        S_RUN
    } state_t;
`endif

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               frame_done_q, frame_done_d;
    logic               err_q, err_d;
    logic               miso_c;
`ifdef QTCORE_WDT_EN
    logic [WDT_W-1:0]   wdt_q, wdt_d;
    logic               halt_sel;
`endif

    // -----------------------------------------------------------------------
    // Helpers
    // -----------------------------------------------------------------------
    function automatic logic sel_valid(input logic [SEL_W-1:0] s);
        return (32'(s) < NUM_CORES);
    endfunction

    // Shift one header bit in at the LSB; after SEL_W shifts the first bit
    // received ends up as the MSB.
    function automatic logic [SEL_W-1:0] shift_in(input logic [SEL_W-1:0] s,
                                                  input logic             b);
        return (s << 1) | SEL_W'(b);
    endfunction

    // One-hot decode; an out-of-range index decodes to all zeros.
    function automatic logic [NUM_CORES-1:0] onehot(input logic [SEL_W-1:0] s);
        logic [NUM_CORES-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (32'(s) == i) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    // Per-core bit pick; an out-of-range index reads as 0.
    function automatic logic pick(input logic [NUM_CORES-1:0] vec,
                                  input logic [SEL_W-1:0]     s);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (32'(s) == i) begin
                r = vec[i];
            end
        end
        return r;
    endfunction

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            sel_q        <= '0;
            cnt_q        <= '0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
`ifdef QTCORE_WDT_EN
            wdt_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            cnt_q        <= cnt_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
`ifdef QTCORE_WDT_EN
            wdt_q        <= wdt_d;
`endif
        end
    end

`ifdef QTCORE_WDT_EN
    assign halt_sel = pick(core_halt, sel_q);
`endif

    // -----------------------------------------------------------------------
    // Next state and outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        cnt_d        = cnt_q;
        frame_done_d = frame_done_q;
        err_d        = err_q;
`ifdef QTCORE_WDT_EN
        wdt_d        = wdt_q;
`endif
        core_scan_en = '0;
        core_scan_in = 1'b0;
        core_proc_en = '0;
        miso_c       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (!pins.scan_cs_n) begin
                    // This edge already carries the first header bit.
                    sel_d        = shift_in(sel_q, pins.sdi);
                    frame_done_d = 1'b0;
                    if (!pins.proc_cs_n) begin
                        err_d = 1'b1;
                    end
                    if (SEL_W == 1) begin
                        state_d = S_SCAN;
                        cnt_d   = '0;
                        if (!sel_valid(sel_d)) begin
                            err_d = 1'b1;
                        end
                    end else begin
                        state_d = S_HDR;
                        cnt_d   = CNT_W'(1);
                    end
                end else if (!pins.proc_cs_n) begin
                    state_d = S_RUN;
`ifdef QTCORE_WDT_EN
                    wdt_d   = '0;
`endif
                end
            end

            S_HDR: begin
                if (pins.scan_cs_n) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                end else begin
                    sel_d = shift_in(sel_q, pins.sdi);
                    if (cnt_q == CNT_W'(SEL_W - 1)) begin
                        state_d = S_SCAN;
                        cnt_d   = '0;
                        if (!sel_valid(sel_d)) begin
                            err_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            S_SCAN: begin
                // An invalid index still runs the full-length count so the
                // host stays in step, but no core sees the bits.
                core_scan_in = pins.sdi;
                if (sel_valid(sel_q)) begin
                    core_scan_en = onehot(sel_q);
                    miso_c       = pick(core_scan_out, sel_q);
                end
                if (pins.scan_cs_n) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                end else if (cnt_q == CNT_W'(SCAN_LEN - 1)) begin
                    // Park the count at SCAN_LEN; it never wraps.
                    state_d      = S_DONE;
                    cnt_d        = CNT_W'(SCAN_LEN);
                    frame_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_DONE: begin
                if (pins.scan_cs_n) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    // Over-long frame: bit is dropped but flagged.
                    err_d = 1'b1;
                end
            end

            S_RUN: begin
                if (sel_valid(sel_q)) begin
                    core_proc_en = onehot(sel_q);
                    miso_c       = pick(core_halt, sel_q);
                end else begin
                    err_d = 1'b1;
                end
                if (pins.proc_cs_n) begin
                    state_d = S_IDLE;
                end
`ifdef QTCORE_WDT_EN
                else if (halt_sel) begin
                    wdt_d = '0;
                end else if (wdt_q == WDT_W'(WDT_CYCLES - 1)) begin
                    state_d = S_WDT;
                    wdt_d   = WDT_W'(WDT_CYCLES);
                    err_d   = 1'b1;
                end else begin
                    wdt_d = wdt_q + WDT_W'(1);
                end
`endif
            end

`ifdef QTCORE_WDT_EN
            S_WDT: begin
                // Report the stopped core as halted so the host moves on.
                miso_c = 1'b1;
                if (pins.proc_cs_n) begin
                    state_d = S_IDLE;
                end
            end
`endif

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign pins.miso  = miso_c;
    assign sel        = sel_q;
    assign frame_done = frame_done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_qtcore_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_qtcore_scan_ctrl
//
// Directed bench for qtcore_scan_ctrl with NUM_CORES=2, SEL_W=3, SCAN_LEN=8,
// WDT_CYCLES=16. A frame-position model predicts every output each cycle;
// literal expectations pin frame timing, data order and the run behaviour.
// Build with QTCORE_WDT_EN to exercise the watchdog expectations.
// ---------------------------------------------------------------------------
module tb_qtcore_scan_ctrl;
    localparam int NUM_CORES  = 2;
    localparam int SEL_W      = 3;
    localparam int SCAN_LEN   = 8;
    localparam int WDT_CYCLES = 16;
    localparam int TOT        = SEL_W + SCAN_LEN;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] core_scan_en;
    logic       core_scan_in;
    logic [1:0] core_scan_out;
    logic [1:0] core_proc_en;
    logic [1:0] core_halt;
    logic [2:0] sel;
    logic       frame_done;
    logic       err;

    qtcore_scan_ctrl_if pins ();

    qtcore_scan_ctrl #(
        .NUM_CORES (NUM_CORES),
        .SEL_W     (SEL_W),
        .SCAN_LEN  (SCAN_LEN),
        .WDT_CYCLES(WDT_CYCLES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pins         (pins),
        .core_scan_en (core_scan_en),
        .core_scan_in (core_scan_in),
        .core_scan_out(core_scan_out),
        .core_proc_en (core_proc_en),
        .core_halt    (core_halt),
        .sel          (sel),
        .frame_done   (frame_done),
        .err          (err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Model: mode 0 idle, 1 inside a scan frame, 2 running, 3 watchdog stop.
    // m_pos counts bits consumed in the current frame (header + scan).
    int m_mode = 0;
    int m_pos  = 0;
    int m_sel  = 0;
    int m_wdt  = 0;
    bit m_err  = 0;
    bit m_fd   = 0;

    function automatic bit idx_ok(input int s);
        return s < NUM_CORES;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_mode = 0; m_pos = 0; m_sel = 0; m_wdt = 0; m_err = 0; m_fd = 0;
            end else begin
                case (m_mode)
                    0: begin
                        if (!pins.scan_cs_n) begin
                            m_mode = 1;
                            m_pos  = 1;
                            m_sel  = (m_sel * 2 + int'(pins.sdi)) % (1 << SEL_W);
                            m_fd   = 0;
                            if (!pins.proc_cs_n) m_err = 1;
                        end else if (!pins.proc_cs_n) begin
                            m_mode = 2;
                            m_wdt  = 0;
                            if (!idx_ok(m_sel)) m_err = 1;
                        end
                    end
                    1: begin
                        if (pins.scan_cs_n) begin
                            if (m_pos < TOT) m_err = 1;
                            m_mode = 0;
                        end else if (m_pos < SEL_W) begin
                            m_sel = (m_sel * 2 + int'(pins.sdi)) % (1 << SEL_W);
                            m_pos++;
                            if (m_pos == SEL_W && !idx_ok(m_sel)) m_err = 1;
                        end else if (m_pos < TOT) begin
                            m_pos++;
                            if (m_pos == TOT) m_fd = 1;
                        end else begin
                            m_err = 1;
                        end
                    end
                    2: begin
                        if (pins.proc_cs_n) begin
                            m_mode = 0;
                        end else begin
`ifdef QTCORE_WDT_EN
                            if (idx_ok(m_sel) && core_halt[m_sel]) begin
                                m_wdt = 0;
                            end else begin
                                m_wdt++;
                                if (m_wdt == WDT_CYCLES) begin
                                    m_mode = 3;
                                    m_err  = 1;
                                end
                            end
`endif
                        end
                    end
                    default: begin
                        if (pins.proc_cs_n) m_mode = 0;
                    end
                endcase
            end
        end
    end

    // Loggers for the literal expectations, cleared by the driver.
    int          en10    = 0;
    int          en_any  = 0;
    int          pen01   = 0;
    int          miso_hi = 0;
    logic [15:0] sbits   = '0;

    initial begin
        logic [1:0] e_sen, e_pen;
        logic       e_sin, e_miso;
        bit         in_scan;
        forever begin
            @(negedge clk);
            e_sen = 2'b00; e_pen = 2'b00; e_sin = 1'b0; e_miso = 1'b0;
            in_scan = (m_mode == 1) && (m_pos >= SEL_W) && (m_pos < TOT);
            if (in_scan) begin
                e_sin = pins.sdi;
                if (idx_ok(m_sel)) begin
                    e_sen  = 2'(1 << m_sel);
                    e_miso = core_scan_out[m_sel];
                end
            end
            if (m_mode == 2 && idx_ok(m_sel)) begin
                e_pen  = 2'(1 << m_sel);
                e_miso = core_halt[m_sel];
            end
            if (m_mode == 3) e_miso = 1'b1;
            chk("cyc_scan_en",    core_scan_en, e_sen);
            chk("cyc_scan_in",    core_scan_in, e_sin);
            chk("cyc_proc_en",    core_proc_en, e_pen);
            chk("cyc_miso",       pins.miso,    e_miso);
            chk("cyc_sel",        sel,          m_sel);
            chk("cyc_frame_done", frame_done,   m_fd);
            chk("cyc_err",        err,          m_err);
            if (core_scan_en == 2'b10) en10++;
            if (core_scan_en != 2'b00) begin
                en_any++;
                sbits = {sbits[14:0], core_scan_in};
            end
            if (core_proc_en == 2'b01) pen01++;
            if (pins.miso) miso_hi++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        core_scan_out = 2'($urandom_range(0, 3));
    endtask

    task automatic clear_logs();
        en10 = 0; en_any = 0; pen01 = 0; miso_hi = 0; sbits = '0;
    endtask

    task automatic do_reset();
        pins.scan_cs_n = 1'b1; pins.proc_cs_n = 1'b1; pins.sdi = 1'b0;
        core_halt = 2'b00;
        rst = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
    endtask

    // Header MSB first, then nbits of data MSB first; leaves scan_cs_n low.
    task automatic send_bits(input logic [2:0] hdr, input logic [15:0] data, input int nbits);
        pins.scan_cs_n = 1'b0;
        for (int i = SEL_W - 1; i >= 0; i--) begin
            pins.sdi = hdr[i];
            tick();
        end
        for (int i = nbits - 1; i >= 0; i--) begin
            pins.sdi = data[i];
            tick();
        end
    endtask

    task automatic end_frame();
        pins.scan_cs_n = 1'b1;
        pins.sdi = 1'b0;
        tick(); tick();
    endtask

    initial begin
        pins.scan_cs_n = 1'b1; pins.proc_cs_n = 1'b1; pins.sdi = 1'b0;
        core_scan_out = 2'b00; core_halt = 2'b00;
        tick(); tick();
        chk("rst_scan_en",    core_scan_en, 2'b00);
        chk("rst_proc_en",    core_proc_en, 2'b00);
        chk("rst_miso",       pins.miso,    1'b0);
        chk("rst_sel",        sel,          3'd0);
        chk("rst_frame_done", frame_done,   1'b0);
        chk("rst_err",        err,          1'b0);
        rst = 1'b1;
        tick();

        // Good frame to core 1 with 0xA5.
        clear_logs();
        send_bits(3'b001, 16'h00A5, 8);
        chk("good_en_cycles",  en10,       8);
        chk("good_frame_done", frame_done, 1'b1);
        chk("good_err",        err,        1'b0);
        chk("good_sel",        sel,        3'd1);
        end_frame();
        chk("good_bits",       sbits[7:0], 8'hA5);
        chk("good_fd_hold",    frame_done, 1'b1);

        // Abort after 4 scan bits.
        do_reset();
        send_bits(3'b001, 16'h000A, 4);
        end_frame();
        chk("abort_frame_done", frame_done, 1'b0);
        chk("abort_err",        err,        1'b1);

        // Over-long frame of 10 bits.
        do_reset();
        clear_logs();
        send_bits(3'b001, 16'h0296, 10);
        chk("long_en_cycles",  en10,       8);
        chk("long_frame_done", frame_done, 1'b1);
        chk("long_err",        err,        1'b1);
        end_frame();

        // Invalid core index 5.
        do_reset();
        clear_logs();
        send_bits(3'b101, 16'h00A5, 8);
        chk("inv_en_cycles", en_any,     0);
        chk("inv_miso_hi",   miso_hi,    0);
        chk("inv_err",       err,        1'b1);
        chk("inv_sel",       sel,        3'd5);
        chk("inv_fd",        frame_done, 1'b1);
        end_frame();

        // Run core 0, halt rises after 20 running cycles.
        do_reset();
        clear_logs();
        pins.proc_cs_n = 1'b0;
        tick();
        repeat (20) tick();
        core_halt = 2'b01;
        @(negedge clk);
        chk("run_miso_rise", pins.miso, 1'b1);
        repeat (5) tick();
        pins.proc_cs_n = 1'b1;
        tick();
`ifdef QTCORE_WDT_EN
        chk("wdt_pen_cycles", pen01,   16);
        chk("wdt_err",        err,     1'b1);
        chk("wdt_miso_hi",    miso_hi, 10);
`else
        chk("run_pen_cycles", pen01,   26);
        chk("run_err",        err,     1'b0);
        chk("run_miso_hi",    miso_hi, 6);
`endif
        core_halt = 2'b00;
        tick();

        // Both selects low together: scan wins, then run core 1.
        do_reset();
        pins.proc_cs_n = 1'b0;
        send_bits(3'b001, 16'h003C, 8);
        chk("both_err",        err,        1'b1);
        chk("both_frame_done", frame_done, 1'b1);
        end_frame();
        core_halt = 2'b10;
        @(negedge clk);
        chk("both_run_pen",  core_proc_en, 2'b10);
        chk("both_run_miso", pins.miso,    1'b1);
        pins.scan_cs_n = 1'b0;
        repeat (3) tick();
        pins.scan_cs_n = 1'b1;
        pins.proc_cs_n = 1'b1;
        tick(); tick();
        core_halt = 2'b00;

        // Asynchronous reset after 5 scan bits.
        do_reset();
        send_bits(3'b001, 16'h0016, 5);
        #2;
        rst = 1'b0;
        #1;
        chk("mrst_scan_en",    core_scan_en, 2'b00);
        chk("mrst_scan_in",    core_scan_in, 1'b0);
        chk("mrst_sel",        sel,          3'd0);
        chk("mrst_err",        err,          1'b0);
        chk("mrst_frame_done", frame_done,   1'b0);
        pins.scan_cs_n = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        chk("mrst_after_en",  core_scan_en, 2'b00);
        chk("mrst_after_pen", core_proc_en, 2'b00);
        chk("mrst_after_sel", sel,          3'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
